// File: rtl/sort_pkg.sv
// Shared sorter parameters and helpers.
// Used by the frame loader, the sorter and the drain stage.
package sort_pkg;

  localparam int SORT_N  = 4;
  localparam int SORT_DW = 8;
  localparam int CNT_W   = $clog2(SORT_N);

  // All-ones filler: it sorts to the top lanes.
  function automatic logic [63:0] pad_value(input int dw);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < dw) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sort_frame_loader_if.sv
// Generic valid/ready stream bundle.
// The bundle is used for both the element stream and the frame stream.
interface sort_frame_loader_if #(
  parameter int W = 8
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/sort_frame_reg.sv
// Output frame holding register.
// The frame is stable while valid is high and ready is low.
module sort_frame_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] frame_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= frame_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sort_frame_loader.sv
// Packs a serial element stream into N-lane frames for the sorter.
// Optional SORT_LOADER_FLUSH_EN adds a flush port that pads partial frames.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int DW = SORT_DW
) (
  input logic clk,
  input logic rst_n,
`ifdef SORT_LOADER_FLUSH_EN
  input logic flush,
`endif
  sort_frame_loader_if.slave  s,
  sort_frame_loader_if.master m
);

  localparam int CW = $clog2(N);
  localparam logic [DW-1:0] PAD = DW'(pad_value(DW));

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [DW*N-1:0] coll_q;
  logic [DW*N-1:0] coll_d;
  logic            coll_full_q;
  logic            coll_full_d;
  logic            s_ready_q;

  logic            accept;
  logic            last;
  logic            do_flush;
  logic            complete;
  logic            out_free;
  logic            load;
  logic [DW*N-1:0] frame_asm;
  logic [DW*N-1:0] load_frame;

  always_comb begin
    accept = s.valid && s_ready_q;
    last   = accept && (cnt_q == CW'(N - 1));
`ifdef SORT_LOADER_FLUSH_EN
    do_flush = flush && s_ready_q
            && ((cnt_q != '0) || accept)
            && !last;
`else
    do_flush = 1'b0;
`endif
    complete = last || do_flush;
    out_free = !m.valid || m.ready;

    // Lanes below cnt come from the collect store.
    frame_asm = coll_q;
    for (int k = 0; k < N; k++) begin
      if (accept && (CW'(k) == cnt_q)) begin
        frame_asm[DW*k +: DW] = s.data;
      end else if (do_flush && (CW'(k) >= cnt_q)) begin
        frame_asm[DW*k +: DW] = PAD;
      end
    end

    load       = out_free && (coll_full_q || complete);
    load_frame = coll_full_q ? coll_q : frame_asm;

    coll_d = (accept || do_flush) ? frame_asm : coll_q;

    if (coll_full_q) coll_full_d = !out_free;
    else             coll_full_d = complete && !out_free;

    if (complete)    cnt_d = '0;
    else if (accept) cnt_d = cnt_q + CW'(1);
    else             cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      coll_q      <= '0;
      coll_full_q <= 1'b0;
      s_ready_q   <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      coll_q      <= coll_d;
      coll_full_q <= coll_full_d;
      s_ready_q   <= !coll_full_d;
    end
  end

  assign s.ready = s_ready_q;

  sort_frame_reg #(
    .W (DW*N)
  ) u_frame_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .frame_i (load_frame),
    .ready_i (m.ready),
    .valid_o (m.valid),
    .data_o  (m.data)
  );

endmodule
